// File: rtl/nmc_pkg.sv
// -----------------------------------------------------------------------------
// nmc_pkg
// Shared definitions for the near-memory-compute DRAM controller slice:
// default widths, the sequencer state encoding and the arbiter grant encoding.
// -----------------------------------------------------------------------------
package nmc_pkg;

    // Default geometry of the NMC bank array.
    localparam int unsigned ADDR_WIDTH_DEF      = 8;
    localparam int unsigned BANK_DATA_WIDTH_DEF = 128;
    localparam int unsigned BANK_NUM_DEF        = 8;
    localparam int unsigned LEN_WIDTH_DEF       = 8;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DRAIN   = 2'd3
    } nmc_state_e;

    // Encoding of the round-robin last_grant flag.
    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_CM = 1'b1;

endpackage : nmc_pkg

// File: rtl/nmc_rr_arb2.sv
// -----------------------------------------------------------------------------
// nmc_rr_arb2
// Two-requester round-robin arbiter. With a single request pending, that
// requester is granted; on a tie the requester not granted last time wins.
// The last_grant flag only moves when the granted command is accepted, so a
// grant offered while the controller is busy never disturbs the rotation.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                arbitration enabled (controller idle)
//   req_wr, req_cm    write / compute requests
//   accept            granted request was taken this cycle
//   gnt_wr, gnt_cm    one-hot (or zero) grants, combinational
// -----------------------------------------------------------------------------
module nmc_rr_arb2
    import nmc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_wr,
    input  logic req_cm,
    input  logic accept,
    output logic gnt_wr,
    output logic gnt_cm
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt_wr = 1'b0;
        gnt_cm = 1'b0;
        if (en) begin
            if (req_wr && req_cm) begin
                if (last_grant_q == GRANT_CM) begin
                    gnt_wr = 1'b1;
                end else begin
                    gnt_cm = 1'b1;
                end
            end else begin
                gnt_wr = req_wr;
                gnt_cm = req_cm;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = gnt_cm ? GRANT_CM : GRANT_WR;
        end
    end

    // Reset to "compute granted last" so the first tie goes to the writer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_CM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule : nmc_rr_arb2

// File: rtl/dram_nmc_ctrl.sv
// -----------------------------------------------------------------------------
// dram_nmc_ctrl
// Sequencer and arbiter for the near-memory-compute DRAM bank array.
// Accepts write jobs (KV fill) and compute jobs (query streaming) from two
// requesters, arbitrates round-robin, sweeps the shared row address for each
// job and drives the array's write / compute controls. After the last query
// beat the controller waits in DRAIN until the array's compute output is no
// longer valid, so a following write can never clobber a pending result.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   wr_cmd_vld/rdy, _addr, _len     write-job command (len = beats-1)
//   wr_data_vld/rdy, wr_data        write beats
//   cm_cmd_vld/rdy, _addr, _len     compute-job command (len = beats-1)
//   cm_data_vld/rdy, cm_data        query beats
//   nmc_addr                        registered array row address
//   nmc_we, nmc_cme                 array write enable / compute enable
//   nmc_d, nmc_cmIn                 array write data / compute input
//   nmc_cmIn_vld, nmc_cmIn_rdy      compute-input handshake to the array
//   nmc_cmOut_vld                   array compute-output valid (observed)
//   busy                            controller not idle
//   done_wr, done_cm                one-cycle job-complete pulses
// -----------------------------------------------------------------------------
module dram_nmc_ctrl
    import nmc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int unsigned BANK_DATA_WIDTH = BANK_DATA_WIDTH_DEF,
    parameter int unsigned BANK_NUM        = BANK_NUM_DEF,
    parameter int unsigned LEN_WIDTH       = LEN_WIDTH_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,

    input  logic                                wr_cmd_vld,
    output logic                                wr_cmd_rdy,
    input  logic [ADDR_WIDTH-1:0]               wr_cmd_addr,
    input  logic [LEN_WIDTH-1:0]                wr_cmd_len,
    input  logic                                wr_data_vld,
    output logic                                wr_data_rdy,
    input  logic [BANK_DATA_WIDTH*BANK_NUM-1:0] wr_data,

    input  logic                                cm_cmd_vld,
    output logic                                cm_cmd_rdy,
    input  logic [ADDR_WIDTH-1:0]               cm_cmd_addr,
    input  logic [LEN_WIDTH-1:0]                cm_cmd_len,
    input  logic                                cm_data_vld,
    output logic                                cm_data_rdy,
    input  logic [BANK_DATA_WIDTH*BANK_NUM-1:0] cm_data,

    output logic [ADDR_WIDTH-1:0]               nmc_addr,
    output logic                                nmc_we,
    output logic                                nmc_cme,
    output logic [BANK_DATA_WIDTH*BANK_NUM-1:0] nmc_d,
    output logic [BANK_DATA_WIDTH*BANK_NUM-1:0] nmc_cmIn,
    output logic                                nmc_cmIn_vld,
    input  logic                                nmc_cmIn_rdy,
    input  logic                                nmc_cmOut_vld,

    output logic                                busy,
    output logic                                done_wr,
    output logic                                done_cm
);

    localparam int unsigned W = BANK_DATA_WIDTH * BANK_NUM;

    nmc_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  done_wr_q, done_wr_d;
    logic                  done_cm_q, done_cm_d;

    logic                  arb_en;
    logic                  gnt_wr;
    logic                  gnt_cm;
    logic                  cmd_accept;
    logic                  beat_acc;

    // -------------------------------------------------------------------------
    // Arbitration: only offered while idle. A grant is only ever raised for a
    // requester whose cmd_vld is high, so a grant is also an accept.
    // -------------------------------------------------------------------------
    assign arb_en     = (state_q == ST_IDLE);
    assign cmd_accept = gnt_wr | gnt_cm;

    nmc_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (arb_en),
        .req_wr (wr_cmd_vld),
        .req_cm (cm_cmd_vld),
        .accept (cmd_accept),
        .gnt_wr (gnt_wr),
        .gnt_cm (gnt_cm)
    );

    assign wr_cmd_rdy = gnt_wr;
    assign cm_cmd_rdy = gnt_cm;

    // -------------------------------------------------------------------------
    // Next-state, counters and array-side outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        addr_cnt_d   = addr_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        done_wr_d    = 1'b0;
        done_cm_d    = 1'b0;
        beat_acc     = 1'b0;
        wr_data_rdy  = 1'b0;
        cm_data_rdy  = 1'b0;
        nmc_we       = 1'b0;
        nmc_cme      = 1'b0;
        nmc_d        = '0;
        nmc_cmIn     = '0;
        nmc_cmIn_vld = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_wr) begin
                    addr_cnt_d = wr_cmd_addr;
                    beat_cnt_d = wr_cmd_len;
                    state_d    = ST_WRITE;
                end else if (gnt_cm) begin
                    addr_cnt_d = cm_cmd_addr;
                    beat_cnt_d = cm_cmd_len;
                    state_d    = ST_COMPUTE;
                end
            end

            ST_WRITE: begin
                wr_data_rdy = 1'b1;
                nmc_we      = wr_data_vld;
                nmc_d       = wr_data;
                beat_acc    = wr_data_vld;
            end

            ST_COMPUTE: begin
                nmc_cme      = 1'b1;
                nmc_cmIn     = cm_data;
                nmc_cmIn_vld = cm_data_vld;
                cm_data_rdy  = nmc_cmIn_rdy;
                beat_acc     = cm_data_vld & nmc_cmIn_rdy;
            end

            ST_DRAIN: begin
                // Hold compute enabled until the array has no result pending.
                nmc_cme = 1'b1;
                if (!nmc_cmOut_vld) begin
                    state_d   = ST_IDLE;
                    done_cm_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Shared beat bookkeeping for WRITE and COMPUTE; the row address
        // wraps naturally at 2^ADDR_WIDTH.
        if (beat_acc) begin
            addr_cnt_d = addr_cnt_q + 1'b1;
            beat_cnt_d = beat_cnt_q - 1'b1;
            if (beat_cnt_q == '0) begin
                if (state_q == ST_WRITE) begin
                    state_d   = ST_IDLE;
                    done_wr_d = 1'b1;
                end else begin
                    state_d   = ST_DRAIN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_cnt_q <= '0;
            beat_cnt_q <= '0;
            done_wr_q  <= 1'b0;
            done_cm_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            done_wr_q  <= done_wr_d;
            done_cm_q  <= done_cm_d;
        end
    end

    assign nmc_addr = addr_cnt_q;
    assign busy     = (state_q != ST_IDLE);
    assign done_wr  = done_wr_q;
    assign done_cm  = done_cm_q;

endmodule : dram_nmc_ctrl

// File: tb/tb_dram_nmc_ctrl.sv
module tb_dram_nmc_ctrl;

    localparam int AW = 8;
    localparam int LW = 8;
    localparam int W  = 1024;

    logic          clk;
    logic          rst_n;
    logic          wr_cmd_vld, wr_cmd_rdy;
    logic [AW-1:0] wr_cmd_addr;
    logic [LW-1:0] wr_cmd_len;
    logic          wr_data_vld, wr_data_rdy;
    logic [W-1:0]  wr_data;
    logic          cm_cmd_vld, cm_cmd_rdy;
    logic [AW-1:0] cm_cmd_addr;
    logic [LW-1:0] cm_cmd_len;
    logic          cm_data_vld, cm_data_rdy;
    logic [W-1:0]  cm_data;
    logic [AW-1:0] nmc_addr;
    logic          nmc_we, nmc_cme;
    logic [W-1:0]  nmc_d, nmc_cmIn;
    logic          nmc_cmIn_vld, nmc_cmIn_rdy, nmc_cmOut_vld;
    logic          busy, done_wr, done_cm;

    dram_nmc_ctrl #(
        .ADDR_WIDTH      (8),
        .BANK_DATA_WIDTH (128),
        .BANK_NUM        (8),
        .LEN_WIDTH       (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_cmd_vld    (wr_cmd_vld),
        .wr_cmd_rdy    (wr_cmd_rdy),
        .wr_cmd_addr   (wr_cmd_addr),
        .wr_cmd_len    (wr_cmd_len),
        .wr_data_vld   (wr_data_vld),
        .wr_data_rdy   (wr_data_rdy),
        .wr_data       (wr_data),
        .cm_cmd_vld    (cm_cmd_vld),
        .cm_cmd_rdy    (cm_cmd_rdy),
        .cm_cmd_addr   (cm_cmd_addr),
        .cm_cmd_len    (cm_cmd_len),
        .cm_data_vld   (cm_data_vld),
        .cm_data_rdy   (cm_data_rdy),
        .cm_data       (cm_data),
        .nmc_addr      (nmc_addr),
        .nmc_we        (nmc_we),
        .nmc_cme       (nmc_cme),
        .nmc_d         (nmc_d),
        .nmc_cmIn      (nmc_cmIn),
        .nmc_cmIn_vld  (nmc_cmIn_vld),
        .nmc_cmIn_rdy  (nmc_cmIn_rdy),
        .nmc_cmOut_vld (nmc_cmOut_vld),
        .busy          (busy),
        .done_wr       (done_wr),
        .done_cm       (done_cm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {K_GWR = 0, K_GCM = 1, K_WB = 2, K_CB = 3, K_DWR = 4, K_DCM = 5} kind_e;
    typedef struct { kind_e kind; logic [7:0] addr; logic [31:0] tag; } ev_t;
    typedef struct { logic [7:0] addr; logic [7:0] len; } job_t;

    ev_t         exp_q[$];
    job_t        wr_jobs[$];
    job_t        cm_jobs[$];
    logic [31:0] wr_tags[$];
    logic [31:0] cm_tags[$];
    bit          wr_gap = 1'b0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [W-1:0] rep(input logic [31:0] t);
        return {32{t}};
    endfunction

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic exp_ev(input kind_e k, input logic [7:0] a, input logic [31:0] t);
        ev_t e;
        e.kind = k; e.addr = a; e.tag = t;
        exp_q.push_back(e);
    endtask

    task automatic exp_job(input bit is_cm, input logic [7:0] a, input logic [7:0] len, input logic [31:0] tb0);
        exp_ev(is_cm ? K_GCM : K_GWR, a, 0);
        for (int i = 0; i <= int'(len); i++)
            exp_ev(is_cm ? K_CB : K_WB, a + 8'(i), tb0 + 32'(i));
        exp_ev(is_cm ? K_DCM : K_DWR, 0, 0);
    endtask

    task automatic push_job(input bit is_cm, input logic [7:0] a, input logic [7:0] len, input logic [31:0] tb0);
        job_t j;
        j.addr = a; j.len = len;
        if (is_cm) cm_jobs.push_back(j); else wr_jobs.push_back(j);
        for (int i = 0; i <= int'(len); i++) begin
            if (is_cm) cm_tags.push_back(tb0 + 32'(i)); else wr_tags.push_back(tb0 + 32'(i));
        end
    endtask

    // Scoreboard monitor: every DUT event pops the next expected event.
    task automatic observe(input kind_e k, input logic [7:0] a, input logic [W-1:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", 1'b0, 64'(k), 64'hFF);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", e.kind == k, 64'(k), 64'(e.kind));
            if (e.kind == k && k != K_DWR && k != K_DCM)
                chk("event_addr", a == e.addr, 64'(a), 64'(e.addr));
            if (e.kind == k && (k == K_WB || k == K_CB))
                chk("event_data", d == rep(e.tag), 64'(d[31:0]), 64'(e.tag));
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done_wr) observe(K_DWR, 0, '0);
                if (done_cm) observe(K_DCM, 0, '0);
                if (wr_cmd_vld && wr_cmd_rdy) observe(K_GWR, wr_cmd_addr, '0);
                if (cm_cmd_vld && cm_cmd_rdy) observe(K_GCM, cm_cmd_addr, '0);
                if (nmc_we) observe(K_WB, nmc_addr, nmc_d);
                if (nmc_cmIn_vld && nmc_cmIn_rdy) observe(K_CB, nmc_addr, nmc_cmIn);
            end
        end
    end

    // Write requester: commands and beats drawn from queues.
    initial begin : wr_src
        bit fc, fd;
        int phase;
        phase = 0;
        wr_cmd_vld = 0; wr_cmd_addr = '0; wr_cmd_len = '0; wr_data_vld = 0; wr_data = '0;
        forever begin
            @(negedge clk);
            fc = wr_cmd_vld && wr_cmd_rdy;
            fd = wr_data_vld && wr_data_rdy;
            @(posedge clk); #1;
            if (fc && wr_jobs.size() > 0) void'(wr_jobs.pop_front());
            if (fd && wr_tags.size() > 0) void'(wr_tags.pop_front());
            phase++;
            wr_cmd_vld = (wr_jobs.size() > 0);
            if (wr_cmd_vld) begin wr_cmd_addr = wr_jobs[0].addr; wr_cmd_len = wr_jobs[0].len; end
            wr_data_vld = (wr_tags.size() > 0) && (!wr_gap || (phase % 3 == 0));
            wr_data = wr_data_vld ? rep(wr_tags[0]) : '0;
        end
    end

    // Compute requester: query beats always valid when queued.
    initial begin : cm_src
        bit fc, fd;
        cm_cmd_vld = 0; cm_cmd_addr = '0; cm_cmd_len = '0; cm_data_vld = 0; cm_data = '0;
        forever begin
            @(negedge clk);
            fc = cm_cmd_vld && cm_cmd_rdy;
            fd = cm_data_vld && cm_data_rdy;
            @(posedge clk); #1;
            if (fc && cm_jobs.size() > 0) void'(cm_jobs.pop_front());
            if (fd && cm_tags.size() > 0) void'(cm_tags.pop_front());
            cm_cmd_vld = (cm_jobs.size() > 0);
            if (cm_cmd_vld) begin cm_cmd_addr = cm_jobs[0].addr; cm_cmd_len = cm_jobs[0].len; end
            cm_data_vld = (cm_tags.size() > 0);
            cm_data = cm_data_vld ? rep(cm_tags[0]) : '0;
        end
    end

    task automatic at_neg1();
        @(negedge clk); #1;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!busy && n < 200);
        chk(name, busy, 64'(busy), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 200);
        chk(name, !busy, 64'(busy), 0);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(nmc_cme && !nmc_cmIn_vld) && n < 200);
        chk(name, nmc_cme && !nmc_cmIn_vld, 64'({nmc_cme, nmc_cmIn_vld}), 64'b10);
    endtask

    initial begin : main
        int nb, nw, n;
        rst_n = 1'b0; nmc_cmIn_rdy = 1'b1; nmc_cmOut_vld = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_addr", nmc_addr == 0, 64'(nmc_addr), 0);
        chk("rst_we_cme", !nmc_we && !nmc_cme && !nmc_cmIn_vld, 64'({nmc_we, nmc_cme, nmc_cmIn_vld}), 0);
        chk("rst_rdy", !wr_cmd_rdy && !cm_cmd_rdy && !wr_data_rdy && !cm_data_rdy,
            64'({wr_cmd_rdy, cm_cmd_rdy, wr_data_rdy, cm_data_rdy}), 0);
        chk("rst_busy_done", !busy && !done_wr && !done_cm, 64'({busy, done_wr, done_cm}), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: write 0x10 len 3, data always valid
        at_neg1();
        exp_job(0, 8'h10, 8'd3, 32'hA0);
        push_job(0, 8'h10, 8'd3, 32'hA0);
        wait_busy("t1_start");
        nb = 1; n = 0;
        while (n < 100) begin @(negedge clk); n++; if (!busy) break; nb++; end
        chk("t1_busy_cycles", nb == 4, 64'(nb), 4);
        chk("t1_done_wr_first_idle", done_wr, 64'(done_wr), 1);

        // 2: compute 0xFE len 2 with a 2-cycle nmc_cmIn_rdy stall, wraps to 0x00
        at_neg1();
        exp_job(1, 8'hFE, 8'd2, 32'hB0);
        push_job(1, 8'hFE, 8'd2, 32'hB0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(nmc_cmIn_vld && nmc_cmIn_rdy) && n < 200);
        chk("t2_first_beat_addr", nmc_cmIn_vld && nmc_addr == 8'hFE, 64'(nmc_addr), 64'hFE);
        @(posedge clk); #1 nmc_cmIn_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t2_stall_rdy_addr", !cm_data_rdy && nmc_addr == 8'hFF && busy,
                64'({cm_data_rdy, nmc_addr}), 64'hFF);
        end
        @(posedge clk); #1 nmc_cmIn_rdy = 1'b1;
        wait_drain("t2_drain_entered");
        wait_idle("t2_idle");

        // 3: DRAIN held by nmc_cmOut_vld for 5 cycles with a write pending
        at_neg1();
        nmc_cmOut_vld = 1'b1;
        exp_job(1, 8'h30, 8'd1, 32'hC0);
        exp_job(0, 8'h50, 8'd0, 32'hD0);
        push_job(1, 8'h30, 8'd1, 32'hC0);
        wait_busy("t3_cm_start");
        #1 push_job(0, 8'h50, 8'd0, 32'hD0);
        wait_drain("t3_drain_entered");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_drain_hold", busy && !done_cm && !wr_cmd_rdy && nmc_cme,
                64'({busy, done_cm, wr_cmd_rdy, nmc_cme}), 64'b1001);
        end
        @(posedge clk); #1 nmc_cmOut_vld = 1'b0;
        @(negedge clk);
        chk("t3_drain_last_cycle", busy && !done_cm, 64'({busy, done_cm}), 64'b10);
        @(negedge clk);
        chk("t3_done_cm", done_cm && !busy, 64'({done_cm, busy}), 64'b10);
        wait_busy("t3_wr_start");
        wait_idle("t3_wr_idle");

        // 4: after reset, ties alternate write, compute, write, compute
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1; @(posedge clk); #1 rst_n = 1'b1;
        at_neg1();
        exp_job(0, 8'h60, 8'd0, 32'h160);
        exp_job(1, 8'h70, 8'd0, 32'h170);
        exp_job(0, 8'h61, 8'd0, 32'h161);
        exp_job(1, 8'h71, 8'd0, 32'h171);
        push_job(0, 8'h60, 8'd0, 32'h160);
        push_job(0, 8'h61, 8'd0, 32'h161);
        push_job(1, 8'h70, 8'd0, 32'h170);
        push_job(1, 8'h71, 8'd0, 32'h171);
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin @(negedge clk); n++; end
        chk("t4_alternation_done", exp_q.size() == 0, 64'(exp_q.size()), 0);
        wait_idle("t4_idle");

        // 5: reset during beat 2 of a 5-beat write
        at_neg1();
        exp_ev(K_GWR, 8'h40, 0);
        exp_ev(K_WB, 8'h40, 32'hE0);
        exp_ev(K_WB, 8'h41, 32'hE1);
        push_job(0, 8'h40, 8'd4, 32'hE0);
        nw = 0; n = 0;
        while (nw < 2 && n < 200) begin @(negedge clk); n++; if (nmc_we) nw++; end
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        wr_jobs.delete(); wr_tags.delete();
        chk("t5_rst_outputs", nmc_addr == 0 && !nmc_we && !busy && !wr_data_rdy && !done_wr,
            64'({nmc_addr, nmc_we, busy, wr_data_rdy, done_wr}), 0);
        @(posedge clk); #1; @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_pending", exp_q.size() == 0, 64'(exp_q.size()), 0);
        at_neg1();
        exp_job(0, 8'h80, 8'd1, 32'hF0);
        push_job(0, 8'h80, 8'd1, 32'hF0);
        wait_busy("t5_restart");
        wait_idle("t5_idle");

        // 6: write beats valid only 1 cycle in 3
        at_neg1();
        wr_gap = 1'b1;
        exp_job(0, 8'h20, 8'd2, 32'h200);
        push_job(0, 8'h20, 8'd2, 32'h200);
        wait_busy("t6_start");
        nb = 1; nw = nmc_we ? 1 : 0; n = 0;
        while (n < 100) begin
            @(negedge clk); n++;
            if (!busy) break;
            nb++;
            if (nmc_we) nw++;
        end
        chk("t6_we_count", nw == 3, 64'(nw), 3);
        chk("t6_busy_range", nb >= 7 && nb <= 9, 64'(nb), 8);
        wr_gap = 1'b0;

        n = 0;
        while (exp_q.size() > 0 && n < 50) begin @(negedge clk); n++; end
        chk("scoreboard_empty", exp_q.size() == 0, 64'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dram_nmc_ctrl
